// File: rtl/run_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : run_pattern_tx
// Brief    : Serial stimulus generator. Emits bursts of run_len ones, each
//            closed by a single zero and followed by gap_len idle zeros,
//            repeated rep+1 times. exp_det flags the cycles in which a Mealy
//            zero detector fed by x_out must fire.
// Revision : 1.0 - initial release
// ============================================================================
module run_pattern_tx #(
  parameter int LEN_W = 4,
  parameter int REP_W = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] run_len,
  input  logic [LEN_W-1:0] gap_len,
  input  logic [REP_W-1:0] rep,
  output logic             x_out,
  output logic             exp_det,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_ones = 2'd1;
  localparam logic [1:0] c_zero = 2'd2;
  localparam logic [1:0] c_gap  = 2'd3;

  localparam logic [LEN_W-1:0] c_len_zero = '0;
  localparam logic [LEN_W-1:0] c_len_one  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] c_rep_zero = '0;
  localparam logic [REP_W-1:0] c_rep_one  = {{(REP_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state, w_state_nxt;
  logic [LEN_W-1:0] r_cnt,   w_cnt_nxt;
  logic [REP_W-1:0] r_bcnt,  w_bcnt_nxt;
  logic [LEN_W-1:0] r_run,   w_run_nxt;
  logic [LEN_W-1:0] r_gap,   w_gap_nxt;
  logic             r_done,  w_done_nxt;

  // Burst boundary: the last zero of a burst, where we either start the
  // next burst or finish the sequence.
  logic w_burst_end;

  // State and datapath registers; reset forces the idle outputs at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= c_idle;
      r_cnt   <= c_len_zero;
      r_bcnt  <= c_rep_zero;
      r_run   <= c_len_zero;
      r_gap   <= c_len_zero;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_run   <= w_run_nxt;
      r_gap   <= w_gap_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and counter logic; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bcnt_nxt  = r_bcnt;
    w_run_nxt   = r_run;
    w_gap_nxt   = r_gap;
    w_done_nxt  = 1'b0;
    w_burst_end = 1'b0;

    if (abort) begin
      w_state_nxt = c_idle;
      w_cnt_nxt   = c_len_zero;
      w_bcnt_nxt  = c_rep_zero;
    end else begin
      case (r_state)
        c_idle: begin
          // A zero run length would produce a malformed burst, so ignore it.
          if (start && (run_len != c_len_zero)) begin
            w_run_nxt   = run_len;
            w_gap_nxt   = gap_len;
            w_cnt_nxt   = run_len - c_len_one;
            w_bcnt_nxt  = rep;
            w_state_nxt = c_ones;
          end
        end
        c_ones: begin
          if (r_cnt == c_len_zero) begin
            w_state_nxt = c_zero;
          end else begin
            w_cnt_nxt = r_cnt - c_len_one;
          end
        end
        c_zero: begin
          if (r_gap != c_len_zero) begin
            w_cnt_nxt   = r_gap - c_len_one;
            w_state_nxt = c_gap;
          end else begin
            w_burst_end = 1'b1;
          end
        end
        c_gap: begin
          if (r_cnt != c_len_zero) begin
            w_cnt_nxt = r_cnt - c_len_one;
          end else begin
            w_burst_end = 1'b1;
          end
        end
        default: w_state_nxt = c_idle;
      endcase

      if (w_burst_end) begin
        if (r_bcnt != c_rep_zero) begin
          w_bcnt_nxt  = r_bcnt - c_rep_one;
          w_cnt_nxt   = r_run - c_len_one;
          w_state_nxt = c_ones;
        end else begin
          w_state_nxt = c_idle;
          w_done_nxt  = 1'b1;
        end
      end
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    x_out   = (r_state == c_ones);
    exp_det = (r_state == c_zero);
    busy    = (r_state != c_idle);
    done    = r_done;
  end

endmodule
`default_nettype wire

// File: tb/tb_run_pattern_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_run_pattern_tx
// Brief    : Scoreboard bench for run_pattern_tx. Stimulus pushes expected
//            per-cycle outputs tagged with their cycle number; a monitor on
//            the falling edge pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_pattern_tx;

  localparam int LEN_W = 4;
  localparam int REP_W = 3;

  logic             clk;
  logic             rstn;
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] run_len;
  logic [LEN_W-1:0] gap_len;
  logic [REP_W-1:0] rep;
  logic             x_out;
  logic             exp_det;
  logic             busy;
  logic             done;

  run_pattern_tx #(.LEN_W(LEN_W), .REP_W(REP_W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .abort   (abort),
    .run_len (run_len),
    .gap_len (gap_len),
    .rep     (rep),
    .x_out   (x_out),
    .exp_det (exp_det),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    int   cyc;
    int   tid;
    logic x;
    logic e;
    logic b;
    logic d;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   det_en = 0;
  logic prev_x = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle n is the period following the n-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle, plus a
  // reference Mealy zero detector (fires on a 1->0 step) against exp_det.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL t%0d stale: entry for cycle %0d never compared (now %0d)", e.tid, e.cyc, cyc);
    end
    while (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      n_cmp++;
      if ({x_out, exp_det, busy, done} !== {e.x, e.e, e.b, e.d}) begin
        n_fail++;
        $display("FAIL t%0d cycle %0d: x/exp/busy/done got %b%b%b%b want %b%b%b%b",
                 e.tid, cyc, x_out, exp_det, busy, done, e.x, e.e, e.b, e.d);
      end
    end
    if (det_en) begin
      n_cmp++;
      if (exp_det !== (~x_out & prev_x)) begin
        n_fail++;
        $display("FAIL detector cycle %0d: exp_det got %b want %b", cyc, exp_det, ~x_out & prev_x);
      end
    end
    prev_x = x_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int tid, input logic x, input logic e,
                      input logic b, input logic d);
    exp_t en;
    en.cyc = c; en.tid = tid; en.x = x; en.e = e; en.b = b; en.d = d;
    q.push_back(en);
  endtask

  // Behavioural model of the waveform: rep+1 bursts, then a done cycle.
  task automatic push_model(input int k, input int tid, input int run,
                            input int gap, input int rp);
    int c;
    c = k + 1;
    for (int r = 0; r <= rp; r++) begin
      for (int i = 0; i < run; i++) begin push(c, tid, 1, 0, 1, 0); c++; end
      push(c, tid, 0, 1, 1, 0); c++;
      for (int i = 0; i < gap; i++) begin push(c, tid, 0, 0, 1, 0); c++; end
    end
    push(c, tid, 0, 0, 0, 1);
  endtask

  // Hand-written waveform: MSB of xv/ev is the first busy cycle.
  task automatic push_vec(input int k, input int tid, input int n,
                          input logic [31:0] xv, input logic [31:0] ev);
    for (int i = 0; i < n; i++) push(k + 1 + i, tid, xv[n-1-i], ev[n-1-i], 1, 0);
    push(k + n + 1, tid, 0, 0, 0, 1);
  endtask

  // Launch one sequence and run through its done cycle.
  task automatic go(input int tid, input int run, input int gap, input int rp,
                    input bit use_model, input logic [31:0] xv,
                    input logic [31:0] ev, input bit disturb);
    int k;
    int len;
    k   = cyc;
    len = (rp + 1) * (run + 1 + gap);
    if (use_model) push_model(k, tid, run, gap, rp);
    else           push_vec(k, tid, len, xv, ev);
    start   = 1'b1;
    run_len = LEN_W'(run);
    gap_len = LEN_W'(gap);
    rep     = REP_W'(rp);
    tick();
    start = 1'b0;
    for (int i = 1; i <= len; i++) begin
      if (disturb && i == 2) begin
        start   = 1'b1;
        run_len = LEN_W'($urandom_range(0, 15));
        gap_len = LEN_W'($urandom_range(0, 15));
        rep     = REP_W'($urandom_range(0, 7));
      end
      if (disturb && i == 3) start = 1'b0;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic idle(input int tid, input int n);
    for (int i = 1; i <= n; i++) push(cyc + i, tid, 0, 0, 0, 0);
    for (int i = 1; i <= n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int run, gap, rp;
    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    run_len = '0; gap_len = '0; rep = '0;

    // Reset state, held and just after release.
    for (int i = 1; i <= 3; i++) push(i, 0, 0, 0, 0, 0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    det_en = 1;
    // t1: run 3, gap 2, rep 1 -> 1110 00 1110 00, done at cycle 13.
    go(1, 3, 2, 1, 0, 32'b1110_0011_1000, 32'b0001_0000_0100, 0);
    // t2: run 1, gap 0, rep 3 -> 10101010.
    go(2, 1, 0, 3, 0, 32'b1010_1010, 32'b0101_0101, 0);
    idle(2, 2);

    // t3: start with run_len 0 is ignored.
    k = cyc;
    for (int i = 1; i <= 4; i++) push(k + i, 3, 0, 0, 0, 0);
    start = 1'b1; run_len = '0; gap_len = 4'd2; rep = 3'd1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();

    // t4: maximum settings, 248 busy cycles with 8 exp_det pulses.
    go(4, 15, 15, 7, 1, 32'd0, 32'd0, 0);
    idle(4, 1);
    det_en = 0;

    // t5: abort during the second ONES cycle.
    k = cyc;
    push(k + 1, 5, 1, 0, 1, 0);
    push(k + 2, 5, 1, 0, 1, 0);
    for (int i = 3; i <= 5; i++) push(k + i, 5, 0, 0, 0, 0);
    start = 1'b1; run_len = 4'd5; gap_len = 4'd1; rep = 3'd2;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(); tick();

    // t6: start and abort together in IDLE.
    k = cyc;
    for (int i = 1; i <= 3; i++) push(k + i, 6, 0, 0, 0, 0);
    start = 1'b1; abort = 1'b1; run_len = 4'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    tick(); tick();

    // t7: asynchronous reset in the first GAP cycle, then a clean rerun.
    k = cyc;
    push(k + 1, 7, 1, 0, 1, 0);
    push(k + 2, 7, 1, 0, 1, 0);
    push(k + 3, 7, 0, 1, 1, 0);
    for (int i = 4; i <= 6; i++) push(k + i, 7, 0, 0, 0, 0);
    start = 1'b1; run_len = 4'd2; gap_len = 4'd3; rep = 3'd0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    go(7, 2, 3, 0, 1, 32'd0, 32'd0, 0);
    idle(7, 1);

    // t8: random legal settings back to back, with a start pulse and input
    // changes mid-sequence, checked against the reference detector too.
    det_en = 1;
    for (int n = 0; n < 8; n++) begin
      run = int'($urandom_range(1, 6));
      gap = int'($urandom_range(0, 3));
      rp  = int'($urandom_range(0, 3));
      if ((rp + 1) * (run + 1 + gap) < 3) run = 2;
      go(8, run, gap, rp, 1, 32'd0, 32'd0, 1);
    end
    idle(8, 3);
    det_en = 0;
    tick();

    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
